vgafb_fifo_wrctl: RTL and testbench

- Write-side controller for the vgafb asynchronous pixel FIFO, entirely in the sys_clk domain.
- Owns the write pointer in binary (RAM address) and Gray (handed to the pixel-clock side) forms.
- Computes full and fill level against the pre-synchronized Gray read pointer.
- Schedules fixed-length burst requests to the memory fetch engine, issuing one only when a whole burst is guaranteed to fit.

---
 rtl/vgafb_fifo_wrctl_pkg.sv | 23 ++
 rtl/vgafb_fifo_wrctl_if.sv | 27 ++
 rtl/vgafb_fifo_wrptr.sv | 28 ++
 rtl/vgafb_fifo_wrctl.sv | 101 ++++++++++
 tb/tb_vgafb_fifo_wrctl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/vgafb_fifo_wrctl_pkg.sv
// Shared types and pointer helpers for the vgafb asynchronous pixel FIFO.
// Common to the write-side controller and the future read-side controller.
package vgafb_fifo_wrctl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Gray/binary conversions on a zero-extended 32-bit container; callers cast to pointer width.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int unsigned i = 1; i < 32; i++) b ^= g >> i;
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/vgafb_fifo_wrctl_if.sv
// Fetch-engine handshake, RAM write port and status of the FIFO write side.
interface vgafb_fifo_wrctl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  enable;
  logic [ADDR_WIDTH:0]   rd_gray_sync;
  logic                  fml_req;
  logic                  fml_ack;
  logic                  wr_valid;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   wr_gray;
  logic                  full;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  clear_ovf;

  modport master (
    input  enable, rd_gray_sync, fml_ack, wr_valid, clear_ovf,
    output fml_req, wr_en, wr_addr, wr_gray, full, level, overflow
  );

  modport slave (
    output enable, rd_gray_sync, fml_ack, wr_valid, clear_ovf,
    input  fml_req, wr_en, wr_addr, wr_gray, full, level, overflow
  );
endinterface

// File: rtl/vgafb_fifo_wrptr.sv
// Binary + Gray pointer register; Gray is registered from the next binary value
// so both forms change on the same edge.
module vgafb_fifo_wrptr
  import vgafb_fifo_wrctl_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] nxt
);

  assign nxt = bin + WIDTH'(inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin  <= '0;
      gray <= '0;
    end else if (inc) begin
      bin  <= nxt;
      gray <= WIDTH'(bin2gray(32'(nxt)));
    end
  end

endmodule

// File: rtl/vgafb_fifo_wrctl.sv
// Write-side controller of the vgafb pixel FIFO (sys_clk domain): pointer, full,
// fill level, sticky overflow and burst-request scheduling.
module vgafb_fifo_wrctl
  import vgafb_fifo_wrctl_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  vgafb_fifo_wrctl_if.master bus
);

  localparam int PW = ADDR_WIDTH + 1;
  // A burst is only requested when this many words or fewer are already held.
  localparam logic [PW-1:0] REQ_MAX   = PW'((1 << ADDR_WIDTH) - BURST_LEN);
  // Full: top two Gray bits inverted, rest equal (also covers ADDR_WIDTH=1).
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] wr_gray;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] level;
  logic [PW-1:0] beats;
  logic [PW-1:0] beats_nxt;
  logic          wr_en;
  logic          full;
  logic          overflow;
  logic          fml_req;
  state_t        state;
  state_t        state_nxt;

  assign full   = (wr_gray ^ bus.rd_gray_sync) == FULL_MASK;
  assign wr_en  = bus.wr_valid & ~full;
  assign rd_bin = PW'(gray2bin(32'(bus.rd_gray_sync)));

  vgafb_fifo_wrptr #(
    .WIDTH(PW)
  ) u_wrptr (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .inc  (wr_en),
    .bin  (wr_bin),
    .gray (wr_gray),
    .nxt  (wr_bin_next)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      level    <= wr_bin_next - rd_bin;
      overflow <= (bus.wr_valid & full) | (overflow & ~bus.clear_ovf);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      beats <= '0;
    end else begin
      state <= state_nxt;
      beats <= beats_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beats_nxt = beats;
    fml_req   = 1'b0;
    unique case (state)
      IDLE: if (bus.enable && level <= REQ_MAX) state_nxt = REQ;
      REQ: begin
        fml_req = 1'b1;
        if (bus.fml_ack) begin
          state_nxt = DATA;
          beats_nxt = PW'(BURST_LEN);
        end
      end
      DATA: begin
        // Dropped words still consume a beat: the fetch engine sends them regardless.
        if (bus.wr_valid) begin
          beats_nxt = beats - PW'(1);
          if (beats == PW'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.fml_req  = fml_req;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_bin[ADDR_WIDTH-1:0];
  assign bus.wr_gray  = wr_gray;
  assign bus.full     = full;
  assign bus.level    = level;
  assign bus.overflow = overflow;

endmodule

// File: tb/tb_vgafb_fifo_wrctl.sv
// Scoreboard bench for vgafb_fifo_wrctl (ADDR_WIDTH=4, BURST_LEN=4).
module tb_vgafb_fifo_wrctl;

  typedef struct {
    logic [3:0] addr;
    logic [4:0] gray;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  logic [4:0] wp = '0;

  vgafb_fifo_wrctl_if #(.ADDR_WIDTH(4)) bus ();

  vgafb_fifo_wrctl #(
    .ADDR_WIDTH(4),
    .BURST_LEN (4)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] gray5(input logic [4:0] x);
    return x ^ (x >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (bus.fml_req) break;
      tick();
    end
    check("req_wait", int'(bus.fml_req), 1);
  endtask

  task automatic ack();
    bus.fml_ack = 1'b1;
    tick();
    bus.fml_ack = 1'b0;
    check("req_drop_after_ack", int'(bus.fml_req), 0);
  endtask

  task automatic beat(input bit push, input logic [3:0] ea, input logic [4:0] eg);
    bus.wr_valid = 1'b1;
    if (push) q.push_back('{ea, eg});
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic mbeat(input bit track);
    if (track) check("full_while_tracking", int'(bus.full), 0);
    beat(1'b1, wp[3:0], gray5(wp + 5'd1));
    wp = wp + 5'd1;
    if (track) bus.rd_gray_sync = gray5(wp);
  endtask

  // Monitor: every RAM write strobe is matched against the next expected entry.
  initial begin
    exp_t e;
    logic [4:0] gb;
    forever begin
      @(negedge clk);
      if (bus.wr_en === 1'b1) begin
        gb = bus.wr_gray;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got wr_addr %0d expected no write at %0t",
                   bus.wr_addr, $time);
        end else begin
          e = q.pop_front();
          check("wr_addr", int'(bus.wr_addr), int'(e.addr));
          @(posedge clk);
          #1;
          check("wr_gray", int'(bus.wr_gray), int'(e.gray));
          check("gray_one_bit", $countones(gb ^ bus.wr_gray), 1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] t_addr [4];
    logic [4:0] t_gray [4];
    t_addr = '{4'd0, 4'd1, 4'd2, 4'd3};
    t_gray = '{5'd1, 5'd3, 5'd2, 5'd6};

    bus.enable = 1'b1;
    bus.rd_gray_sync = '0;
    bus.fml_ack = 1'b0;
    bus.wr_valid = 1'b0;
    bus.clear_ovf = 1'b0;

    // 1: reset values, then request one edge after release
    tick();
    tick();
    check("rst_fml_req", int'(bus.fml_req), 0);
    check("rst_level", int'(bus.level), 0);
    check("rst_full", int'(bus.full), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    check("rst_wr_gray", int'(bus.wr_gray), 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_req_low", int'(bus.fml_req), 0);
    tick();
    check("first_req", int'(bus.fml_req), 1);

    // 2: first burst against hand-computed addresses / Gray codes
    ack();
    for (int i = 0; i < 4; i++) beat(1'b1, t_addr[i], t_gray[i]);
    wp = 5'd4;
    check("level_after_burst1", int'(bus.level), 4);
    check("idle_after_burst1", int'(bus.fml_req), 0);
    tick();
    check("second_req", int'(bus.fml_req), 1);

    // 3: read pointer stuck at 0, three more bursts fill the FIFO
    for (int b = 0; b < 3; b++) begin
      wait_req();
      ack();
      for (int i = 0; i < 4; i++) mbeat(1'b0);
      check("level_fill", int'(bus.level), 4 * (b + 2));
    end
    check("full_at_16", int'(bus.full), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_fifth_req", int'(bus.fml_req), 0);
    end
    check("level_16", int'(bus.level), 16);

    // 4: overflow on drop, sticky, set beats clear
    bus.wr_valid = 1'b1;
    #1;
    check("wr_en_when_full", int'(bus.wr_en), 0);
    tick();
    bus.wr_valid = 1'b0;
    check("ovf_set", int'(bus.overflow), 1);
    check("ptr_hold_addr", int'(bus.wr_addr), 0);
    check("ptr_hold_gray", int'(bus.wr_gray), 24);
    tick();
    tick();
    check("ovf_sticky", int'(bus.overflow), 1);
    bus.wr_valid = 1'b1;
    bus.clear_ovf = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    check("ovf_set_beats_clear", int'(bus.overflow), 1);
    tick();
    bus.clear_ovf = 1'b0;
    check("ovf_cleared", int'(bus.overflow), 0);

    // 5: read side drains and then tracks the writer across the pointer wrap
    bus.rd_gray_sync = gray5(5'd16);
    #1;
    check("full_released", int'(bus.full), 0);
    tick();
    check("level_drained", int'(bus.level), 0);
    for (int b = 0; b < 10; b++) begin
      wait_req();
      ack();
      for (int i = 0; i < 4; i++) mbeat(1'b1);
      check("level_tracking", int'(bus.level), 1);
    end
    check("wrapped_addr", int'(bus.wr_addr), 8);
    check("wrapped_gray", int'(bus.wr_gray), int'(gray5(5'd24)));

    // 6: enable drop during REQ, then reset in DATA
    wait_req();
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("req_held_no_enable", int'(bus.fml_req), 1);
    end
    ack();
    for (int i = 0; i < 4; i++) mbeat(1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_req_disabled", int'(bus.fml_req), 0);
    end
    bus.enable = 1'b1;
    wait_req();
    ack();
    mbeat(1'b1);
    mbeat(1'b1);
    #2;
    rst_n = 1'b0;
    bus.rd_gray_sync = '0;
    #1;
    check("arst_fml_req", int'(bus.fml_req), 0);
    check("arst_level", int'(bus.level), 0);
    check("arst_wr_gray", int'(bus.wr_gray), 0);
    check("arst_wr_addr", int'(bus.wr_addr), 0);
    check("arst_full", int'(bus.full), 0);
    check("arst_overflow", int'(bus.overflow), 0);
    wp = '0;
    tick();
    rst_n = 1'b1;
    tick();
    check("scoreboard_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
